// File: rtl/sleep_pkg.sv
// Shared definitions for the idle-detect path: FSM state encoding and the
// constants both the zero detector and the fade controller agree on.
package sleep_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE   = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SLEEP    = 2'd2,
        ST_FADE_IN  = 2'd3
    } sleep_state_e;

    localparam int FADE_LEN_DEF    = 64;
    // Consecutive silent stereo samples before the zero detector raises sleep.
    localparam int ZERO_RUN_THRESH = 800;

endpackage

// File: rtl/fade_gain_mul.sv
// Combinational signed sample x unsigned gain, arithmetic shift back to unity.
// gain == 2**SHIFT is bit-exact passthrough, gain == 0 is exact zero.
module fade_gain_mul #(
    parameter int GAIN_W = 7,
    parameter int SHIFT  = 6
) (
    input  logic signed [15:0]       sample,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [15:0]       scaled
);

    localparam int PW = 16 + GAIN_W + 1;

    logic signed [PW-1:0] product;

    always_comb begin
        // Zero-extend gain before going signed so it never reads as negative.
        product = PW'(sample) * PW'($signed({1'b0, gain}));
        scaled  = 16'(product >>> SHIFT);
    end

endmodule

// File: rtl/sleep_fade_ctrl.sv
// Sleep-entry/exit fader: ramps L/R gain to zero on sleep request, holds
// silence while asleep, ramps back to unity on wake. Updates only on strobes.
module sleep_fade_ctrl
    import sleep_pkg::*;
#(
    parameter int FADE_LEN = FADE_LEN_DEF,
    parameter int GAIN_W   = $clog2(FADE_LEN) + 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_status,
    input  logic         sleep_status,
    input  logic [15:0]  InputL,
    input  logic [15:0]  InputR,
    output logic [15:0]  OutL,
    output logic [15:0]  OutR,
    output logic         OutReady,
    output logic         asleep,
    output logic         fading,
    output sleep_state_e state_dbg
);

    // Handshake: in_status qualifies InputL/InputR/sleep_status for one cycle;
    // OutReady is a one-cycle valid for OutL/OutR with no back-pressure.

    localparam logic [GAIN_W-1:0] GAIN_MAX  = GAIN_W'(FADE_LEN);
    localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);
    localparam logic [GAIN_W-1:0] GAIN_ZERO = '0;

    sleep_state_e      state_q, state_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [15:0]       out_l_q, out_l_d, out_r_q, out_r_d;
    logic              out_ready_q, out_ready_d;
    logic              asleep_q, asleep_d, fading_q, fading_d;
    logic [15:0]       mul_l, mul_r;

    fade_gain_mul #(.GAIN_W(GAIN_W), .SHIFT($clog2(FADE_LEN))) u_mul_l (
        .sample (InputL),
        .gain   (gain_q),
        .scaled (mul_l)
    );

    fade_gain_mul #(.GAIN_W(GAIN_W), .SHIFT($clog2(FADE_LEN))) u_mul_r (
        .sample (InputR),
        .gain   (gain_q),
        .scaled (mul_r)
    );

    always_comb begin
        state_d     = state_q;
        gain_d      = gain_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        out_ready_d = 1'b0;
        if (in_status) begin
            out_l_d     = mul_l;
            out_r_d     = mul_r;
            out_ready_d = 1'b1;
            // sleep_status always wins over reaching an endpoint on the same sample.
            case (state_q)
                ST_ACTIVE: begin
                    if (sleep_status) begin
                        state_d = ST_FADE_OUT;
                        gain_d  = GAIN_MAX - GAIN_ONE;
                    end else begin
                        gain_d  = GAIN_MAX;
                    end
                end
                ST_SLEEP: begin
                    if (sleep_status) begin
                        gain_d  = GAIN_ZERO;
                    end else begin
                        state_d = ST_FADE_IN;
                        gain_d  = GAIN_ONE;
                    end
                end
                ST_FADE_OUT, ST_FADE_IN: begin
                    if (sleep_status) begin
                        gain_d  = (gain_q == GAIN_ZERO) ? GAIN_ZERO : gain_q - GAIN_ONE;
                        state_d = (gain_d == GAIN_ZERO) ? ST_SLEEP : ST_FADE_OUT;
                    end else begin
                        gain_d  = (gain_q == GAIN_MAX) ? GAIN_MAX : gain_q + GAIN_ONE;
                        state_d = (gain_d == GAIN_MAX) ? ST_ACTIVE : ST_FADE_IN;
                    end
                end
                default: begin
                    state_d = ST_ACTIVE;
                    gain_d  = GAIN_MAX;
                end
            endcase
        end
        asleep_d = (state_d == ST_SLEEP);
        fading_d = (state_d == ST_FADE_OUT) || (state_d == ST_FADE_IN);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_ACTIVE;
            gain_q      <= GAIN_MAX;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_ready_q <= 1'b0;
            asleep_q    <= 1'b0;
            fading_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_ready_q <= out_ready_d;
            asleep_q    <= asleep_d;
            fading_q    <= fading_d;
        end
    end

    assign OutL      = out_l_q;
    assign OutR      = out_r_q;
    assign OutReady  = out_ready_q;
    assign asleep    = asleep_q;
    assign fading    = fading_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sleep_fade_ctrl.sv
// Directed bench for sleep_fade_ctrl at FADE_LEN=64: passthrough, fade out,
// sleep, fade in, mid-fade reversal, endpoint races and reset mid-fade.
module tb_sleep_fade_ctrl;
    import sleep_pkg::*;

    logic         clk;
    logic         reset;
    logic         in_status;
    logic         sleep_status;
    logic [15:0]  input_l, input_r;
    logic [15:0]  out_l, out_r;
    logic         out_ready, asleep, fading;
    sleep_state_e state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    sleep_fade_ctrl dut (
        .Clk          (clk),
        .Reset        (reset),
        .in_status    (in_status),
        .sleep_status (sleep_status),
        .InputL       (input_l),
        .InputR       (input_r),
        .OutL         (out_l),
        .OutR         (out_r),
        .OutReady     (out_ready),
        .asleep       (asleep),
        .fading       (fading),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at a negedge; presents one strobe and returns at the next negedge,
    // where the registered result of that strobe is visible.
    task automatic step(input logic sl, input logic [15:0] l, input logic [15:0] r);
        sleep_status = sl;
        input_l      = l;
        input_r      = r;
        in_status    = 1'b1;
        @(negedge clk);
        in_status    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic [15:0] el, input logic [15:0] er);
        check_eq({tag, "_l"}, 32'(out_l), 32'(el));
        check_eq({tag, "_r"}, 32'(out_r), 32'(er));
        check_eq({tag, "_rdy"}, 32'(out_ready), 32'd1);
    endtask

    initial begin
        reset        = 1'b1;
        in_status    = 1'b0;
        sleep_status = 1'b0;
        input_l      = '0;
        input_r      = '0;
        idle(3);
        check_eq("rst_outl", 32'(out_l), 32'h0);
        check_eq("rst_outr", 32'(out_r), 32'h0);
        check_eq("rst_rdy", 32'(out_ready), 32'd0);
        check_eq("rst_asleep", 32'(asleep), 32'd0);
        check_eq("rst_fading", 32'(fading), 32'd0);
        check_eq("rst_state", 32'(state_dbg), 32'(ST_ACTIVE));
        reset = 1'b0;
        idle(1);

        // passthrough at unity, one strobe every 4 cycles
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 16'h4000, 16'hC000);
            check_out("pass", 16'h4000, 16'hC000);
            check_eq("pass_asleep", 32'(asleep), 32'd0);
            check_eq("pass_fading", 32'(fading), 32'd0);
            idle(1);
            check_eq("pass_rdy_low", 32'(out_ready), 32'd0);
            idle(2);
        end

        // fade out: gain 64 down to 1, outputs step by 0x0100; asleep after 64 samples
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 16'h4000, 16'h4000);
            check_out("fout", 16'(32'h4000 - k * 32'h100), 16'(32'h4000 - k * 32'h100));
            check_eq("fout_asleep", 32'(asleep), (k == 63) ? 32'd1 : 32'd0);
            check_eq("fout_fading", 32'(fading), (k == 63) ? 32'd0 : 32'd1);
        end

        // asleep with full-scale input: silent but still framing every sample
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h7FFF, 16'h7FFF);
            check_out("sleep", 16'h0000, 16'h0000);
            check_eq("sleep_state", 32'(state_dbg), 32'(ST_SLEEP));
        end

        // wake: first sample still at gain 0, then 0x0100 .. 0x4000
        for (int k = 0; k <= 64; k++) begin
            step(1'b0, 16'h4000, 16'h4000);
            check_out("fin", 16'(k * 32'h100), 16'(k * 32'h100));
            check_eq("fin_fading", 32'(fading), (k < 63) ? 32'd1 : 32'd0);
            check_eq("fin_asleep", 32'(asleep), 32'd0);
        end
        check_eq("fin_state", 32'(state_dbg), 32'(ST_ACTIVE));

        // fade out 25 samples: gain 64 -> 39
        for (int k = 0; k < 25; k++) begin
            step(1'b1, 16'h4000, 16'h4000);
            check_out("rev_out", 16'(32'h4000 - k * 32'h100), 16'(32'h4000 - k * 32'h100));
        end
        // sleep drops: gain climbs 39 -> 45 from where it was
        for (int g = 39; g < 45; g++) begin
            step(1'b0, 16'h4000, 16'h4000);
            check_out("rev_up", 16'(g * 32'h100), 16'(g * 32'h100));
            check_eq("rev_up_state", 32'(state_dbg), 32'(ST_FADE_IN));
        end
        // sleep returns: descend from 45 without a jump, down to 33
        for (int g = 45; g > 32; g--) begin
            step(1'b1, 16'h4000, 16'h4000);
            check_out("rev_dn", 16'(g * 32'h100), 16'(g * 32'h100));
            check_eq("rev_dn_state", 32'(state_dbg), 32'(ST_FADE_OUT));
        end
        // most negative input at half gain shifts arithmetically
        step(1'b1, 16'h8000, 16'h8000);
        check_out("neg_half", 16'hC000, 16'hC000);

        // continue fade-out 31 -> 1
        for (int g = 31; g > 1; g--) begin
            step(1'b1, 16'h4000, 16'h4000);
            check_eq("fout2_l", 32'(out_l), 32'(g * 32'h100));
        end
        // release at gain 1: turns around instead of entering sleep
        step(1'b0, 16'h4000, 16'h4000);
        check_out("edge_lo", 16'h0100, 16'h0100);
        check_eq("edge_lo_state", 32'(state_dbg), 32'(ST_FADE_IN));
        check_eq("edge_lo_asleep", 32'(asleep), 32'd0);
        step(1'b1, 16'h4000, 16'h4000);
        check_eq("edge_g2", 32'(out_l), 32'h0200);
        step(1'b1, 16'h4000, 16'h4000);
        check_eq("edge_g1", 32'(out_l), 32'h0100);
        check_eq("edge_asleep", 32'(asleep), 32'd1);

        // wake up to gain 10 in FADE_IN
        for (int g = 0; g < 10; g++) begin
            step(1'b0, 16'h4000, 16'hC000);
            check_eq("fin2_l", 32'(out_l), 32'(g * 32'h100));
        end
        check_eq("fin2_fading", 32'(fading), 32'd1);

        // reset coincident with a strobe wins, returns to unity with no fade
        reset        = 1'b1;
        sleep_status = 1'b0;
        input_l      = 16'h4000;
        input_r      = 16'hC000;
        in_status    = 1'b1;
        @(negedge clk);
        in_status    = 1'b0;
        check_eq("rst2_outl", 32'(out_l), 32'h0);
        check_eq("rst2_outr", 32'(out_r), 32'h0);
        check_eq("rst2_rdy", 32'(out_ready), 32'd0);
        check_eq("rst2_asleep", 32'(asleep), 32'd0);
        check_eq("rst2_fading", 32'(fading), 32'd0);
        check_eq("rst2_state", 32'(state_dbg), 32'(ST_ACTIVE));
        reset = 1'b0;
        step(1'b0, 16'h4000, 16'hC000);
        check_out("post_rst", 16'h4000, 16'hC000);
        check_eq("post_rst_fading", 32'(fading), 32'd0);
        idle(1);
        check_eq("post_rst_rdy_low", 32'(out_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sleep_fade_ctrl.md
# sleep_fade_ctrl

Consumer end of the idle-detect path. Takes the sleep indication raised by the zero detector after a run of silent stereo samples and drives the output stage accordingly. On entry to sleep it ramps the L/R gain down to zero, holds silence while asleep, and on wake ramps back to unity. This keeps sleep entry and exit free of clicks. It sits between the processing chain output and the DAC-side serializer, in the same sample-strobe domain as the zero detector.

## Interface
- FADE_LEN, 64: fade length in samples; power of two, 2..1024.
- GAIN_W, 7: gain counter width, = log2(FADE_LEN)+1.
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_status  input  1  sample strobe; one-Clk-cycle pulse per stereo sample.
- sleep_status  input  1  sleep request from the zero detector; level; sampled only on in_status cycles.
- InputL  input  16  left sample, two's complement.
- InputR  input  16  right sample, two's complement.
- OutL  output  16  gain-scaled left sample, registered.
- OutR  output  16  gain-scaled right sample, registered.
- OutReady  output  1  one-cycle pulse; OutL/OutR valid.
- asleep  output  1  high while in SLEEP.
- fading  output  1  high while in FADE_OUT or FADE_IN.

## Operation
- States: ACTIVE, FADE_OUT, SLEEP, FADE_IN.
- gain: unsigned counter, range 0..FADE_LEN.
- All state and gain updates occur only on Clk edges where in_status=1. Otherwise everything holds, apart from OutReady clearing.
- Per-sample output is Out = (Input * gain) >>> log2(FADE_LEN). The product is signed 16×GAIN_W, shifted arithmetically, then truncated to 16 bits. gain is the pre-update value.
- gain=FADE_LEN gives bit-exact passthrough. gain=0 gives exact 0.
- ACTIVE: gain=FADE_LEN. If sleep_status=1, go to FADE_OUT and decrement gain on this sample.
- FADE_OUT: decrement gain by 1 per sample.
  - When gain becomes 0 while sleep_status=1, go to SLEEP.
  - If sleep_status=0, go to FADE_IN and increment gain from its current value on this sample. No restart.
- SLEEP: gain=0 and outputs are 0. OutReady still pulses every sample so the serializer keeps framing. If sleep_status=0, go to FADE_IN and set gain to 1.
- FADE_IN: increment gain by 1 per sample.
  - When gain reaches FADE_LEN, go to ACTIVE.
  - If sleep_status=1, go to FADE_OUT and decrement from the current gain.
- Saturation: gain never goes below 0 or above FADE_LEN.
- Simultaneous events: a reaching-endpoint transition and a sleep_status change on the same sample resolve toward the sleep_status request. Example: FADE_IN at gain FADE_LEN-1 with sleep_status=1 goes to FADE_OUT with gain FADE_LEN-2.
- asleep = (state==SLEEP). fading = (state==FADE_OUT or FADE_IN). Both are registered and reflect the post-update state.

## Timing
- Latency: OutL/OutR/OutReady appear on the first Clk edge after the in_status cycle. Latency is 1 cycle, and OutReady is high for exactly one cycle.
- Back-to-back in_status on consecutive cycles must be supported, producing one output per cycle.
- Full fade in either direction takes FADE_LEN samples. Sleep→active takes FADE_LEN samples after the first sample with sleep_status=0.
- Reset values: state=ACTIVE, gain=FADE_LEN, OutL=0, OutR=0, OutReady=0, asleep=0, fading=0.
- Reset has priority over in_status on the same edge.
- Reset mid-fade or in SLEEP returns directly to ACTIVE at unity gain. No fade.

## Structure
- Shared package `sleep_pkg`:
  - the state enum;
  - default FADE_LEN;
  - the zero-run threshold constant (800) used by the zero detector, so both ends share one definition.
- One sub-module: `fade_gain_mul`. It is a combinational signed 16×GAIN_W multiply-and-shift, instanced once for L and once for R. The FSM, gain counter and output registers stay in the top.

## Test plan
- Reset, then in_status each 4 cycles with InputL=0x4000, InputR=0xC000 and sleep_status=0. Expect OutL=0x4000, OutR=0xC000 one cycle after each strobe, asleep=0 and fading=0.
- Raise sleep_status with constant InputL=0x4000 (FADE_LEN=64). Expect OutL steps of 0x0100 downward: 0x4000, 0x3F00, … 0x0100, then 0. asleep rises after 64 samples.
- Hold SLEEP with nonzero input (0x7FFF). Expect OutL=OutR=0 and OutReady still pulsing every sample.
- Drop sleep_status with InputL=0x4000. Expect OutL 0x0100, 0x0200, … 0x4000. fading stays high for 64 samples, then state is ACTIVE.
- Toggle sleep_status to 0 at fade-out gain 40, then back to 1 at gain 45.
  - Expect gain 39→40→…→45.
  - Expect direction reversal with no jump.
  - InputL=0x8000 at gain 32 must give 0xC000, confirming arithmetic shift.
- Assert Reset mid-FADE_IN at gain 10, coincident with in_status. Expect outputs zeroed, next sample passthrough at unity gain, and asleep=fading=0.
